// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and default byte width.
// One-hot states match the transmitter's FSM style.
package uart_pkg;

   localparam int UART_BITS = 8;

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_ACCEPT  = 5'b00010,
      S_ISSUE   = 5'b00100,
      S_WAIT_HI = 5'b01000,
      S_WAIT_LO = 5'b10000
   } sched_state_t;

   // Successor of id in a ring of n entries.
   function automatic int next_rr(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping; purely combinational.
// No handshake; any flags whether idx is meaningful.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   int cand;

   // Scan from the far end so the lowest offset from ptr wins without a break.
   always_comb begin
      idx  = '0;
      cand = 0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (req[cand[IW-1:0]]) begin
            idx = cand[IW-1:0];
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter; grant held for a whole message (or MAX_MSG bytes).
// 1 cycle to grant, +1 to req_ready; next byte only after tx_data_sent has risen and fallen.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BITS    = UART_BITS,
   parameter int MAX_MSG = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*BITS-1:0]    req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [BITS-1:0]            tx_data,
   output logic                       tx_data_ready,
   input  logic                       tx_data_sent,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int IDW   = $clog2(NUM_REQ);
   localparam int CNT_W = (MAX_MSG == 0) ? 1 : $clog2(MAX_MSG + 1);

   sched_state_t     state;
   logic [IDW-1:0]   pointer;
   logic             last_flag;
   logic [CNT_W-1:0] count;

   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic             cap_hit;
   logic [BITS-1:0]  slot_data [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      assign slot_data[g] = req_data[g*BITS +: BITS];
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IDW)
   ) u_pick (
      .req (req_valid),
      .ptr (pointer),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign cap_hit = (MAX_MSG != 0) && (count == CNT_W'(MAX_MSG));

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         pointer       <= '0;
         last_flag     <= 1'b0;
         count         <= '0;
         req_ready     <= '0;
         tx_data       <= '0;
         tx_data_ready <= 1'b0;
         grant_id      <= '0;
         busy          <= 1'b0;
      end else begin
         req_ready     <= '0;
         tx_data_ready <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_idx;
                  busy     <= 1'b1;
                  state    <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               // Owner may pause between bytes; the grant is kept indefinitely.
               if (req_valid[grant_id]) begin
                  req_ready     <= NUM_REQ'(1) << grant_id;
                  tx_data       <= slot_data[grant_id];
                  tx_data_ready <= 1'b1;
                  last_flag     <= req_last[grant_id];
                  if (count != {CNT_W{1'b1}}) begin
                     count <= count + CNT_W'(1);
                  end
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (tx_data_sent) begin
                  state <= S_WAIT_LO;
               end
            end
            S_WAIT_LO: begin
               // The transmitter only accepts a new start once its completion level has cleared.
               if (!tx_data_sent) begin
                  if (last_flag || cap_hit) begin
                     pointer <= IDW'(next_rr(int'(grant_id), NUM_REQ));
                     busy    <= 1'b0;
                     count   <= '0;
                     state   <= S_IDLE;
                  end else begin
                     state <= S_ACCEPT;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one serial transmitter between NUM_REQ byte-stream requesters.
- Each requester presents bytes with a valid/ready handshake and marks message ends with a last flag. The scheduler grants round-robin and holds the grant for a whole message, so messages never interleave on the line.
- Sits between client logic (command responders, debug printers) and the transmitter's data / data_ready / data_sent interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BITS, 8, byte width; must match the transmitter
MAX_MSG, 64, maximum bytes per grant before forced re-arbitration; 0 = unlimited

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*BITS  packed bytes, requester i at [i*BITS +: BITS]
req_last  in  NUM_REQ  byte is final of message
req_ready  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
tx_data  out  BITS  byte to transmitter
tx_data_ready  out  1  one-cycle start pulse to transmitter
tx_data_sent  in  1  transmitter completion level (high through stop bit, clears once back idle)
grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy
busy  out  1  a message is in progress

Behaviour:
- Reset values: req_ready=0, tx_data=0, tx_data_ready=0, grant_id=0, busy=0, round-robin pointer=0, state=IDLE. Reset mid-byte abandons the byte; the transmitter shares rst and also returns to idle.
- States:
  - IDLE: no owner. When any req_valid is set, pick the first valid index at or after pointer (wrapping), set grant_id, busy=1, and go to ACCEPT the next cycle.
  - ACCEPT: if req_valid[grant_id], pulse req_ready[grant_id] for exactly 1 cycle, register tx_data<=req_data slice, latch last flag, increment byte count, and go to ISSUE. If the owner deasserts valid mid-message, stay in ACCEPT and keep the grant; no timeout.
  - ISSUE: tx_data_ready=1 for exactly one cycle, then go to WAIT_HI. tx_data is held stable from ISSUE until the next ACCEPT.
  - WAIT_HI: wait for tx_data_sent==1.
  - WAIT_LO: wait for tx_data_sent==0. Only then is the transmitter idle and able to accept the next start pulse; pulsing earlier is lost.
  - WAIT_LO exit:
    - latched last=1, or byte count==MAX_MSG (MAX_MSG!=0): pointer<=grant_id+1 mod NUM_REQ, busy=0, count=0, go to IDLE.
    - otherwise: go to ACCEPT.
- Throughput: one byte per transmitter frame plus 3 cycles of overhead (ACCEPT, ISSUE, WAIT_HI sampling).
- Arbitration latency: 1 cycle from IDLE with valid to grant_id/busy, +1 cycle to req_ready.
- Requests arriving while busy wait. A requester dropping valid before being granted is simply skipped.
- A single requester with continuous messages is re-granted after its message ends if no other requester is valid. Fairness comes from the pointer only.
- Byte counter width is $clog2(MAX_MSG+1) and saturates; MAX_MSG=0 disables it.
- req_ready is never asserted to a non-owner. At most one req_ready is high per cycle.

Decomposition:
- Shared package uart_pkg: state encoding (one-hot, 4/5 states matching the transmitter's style), UART_BITS default.
- Sub-module rr_pick: combinational round-robin priority encoder (request vector + pointer -> index, any). Reusable for a future RX dispatcher.

Test Plan:
- Single requester 0 sends 0x55,0xA3(last) -> tx_data_ready pulses twice, 0x55 then 0xA3. Second pulse only after tx_data_sent falls. busy drops after the final falling edge, grant_id=0 throughout.
- Requesters 1 and 2 both valid from IDLE, pointer=0 -> grant 1 first; its 3-byte message completes uninterrupted; then grant 2; pointer ends at 3.
- Requester 0 streams without last, MAX_MSG=4, requester 3 valid -> after 4 bytes grant moves to 3. Requester 0 resumes after 3's message.
- Owner drops req_valid for 100 cycles mid-message while requester 1 is valid -> grant held, no tx_data_ready, no req_ready[1]. Resume completes the message.
- tx_data_sent held high 40 cycles (slow transmitter model) -> no second tx_data_ready until it falls. Exactly one pulse per byte is checked by counting.
- rst asserted in WAIT_HI -> next cycle all outputs are at reset values. A new request after rst is granted from pointer 0.
